// File: rtl/shift_pkg.sv
// Shared encodings for the sequenced shift register: fill kinds, directions
// and the command FSM states.
package shift_pkg;

   localparam logic [1:0] KIND_LOGIC = 2'd0;
   localparam logic [1:0] KIND_ARITH = 2'd1;
   localparam logic [1:0] KIND_ROT   = 2'd2;
   localparam logic [1:0] KIND_SER   = 2'd3;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shifter: one step in the given direction with
// the selected fill, plus the bit that falls off the end.
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q,
   input  logic             dir,
   input  logic [1:0]       kind,
   input  logic             ser_in,
   output logic [WIDTH-1:0] q_next,
   output logic             out_bit
);

   logic fill;

   always_comb begin
      fill    = 1'b0;
      q_next  = q;
      out_bit = 1'b0;
      if (dir == DIR_RIGHT) begin
         out_bit = q[0];
         case (kind)
            KIND_ARITH: fill = q[WIDTH-1];
            KIND_ROT:   fill = q[0];
            KIND_SER:   fill = ser_in;
            default:    fill = 1'b0;
         endcase
         q_next = {fill, q[WIDTH-1:1]};
      end else begin
         out_bit = q[WIDTH-1];
         // arithmetic left is identical to logical left
         case (kind)
            KIND_ROT: fill = q[WIDTH-1];
            KIND_SER: fill = ser_in;
            default:  fill = 1'b0;
         endcase
         q_next = {q[WIDTH-2:0], fill};
      end
   end

endmodule

// File: rtl/shift_reg_seq.sv
// Sequenced shift register: a start command performs amt single-position
// shifts, one per enabled cycle, then pulses done.
module shift_reg_seq
   import shift_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = $clog2(WIDTH) + 2
) (
   input  logic             clk,
   input  logic             areset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic             start,
   input  logic             dir,
   input  logic [1:0]       kind,
   input  logic [AMT_W-1:0] amt,
   input  logic             ser_in,
   input  logic             ena,
   output logic [WIDTH-1:0] q,
   output logic             ser_out,
   output logic             busy,
   output logic             done
);

   state_t           state, state_n;
   logic [AMT_W-1:0] cnt, cnt_n;
   logic [WIDTH-1:0] q_n, step_q;
   logic             ser_out_n, done_n, step_out;
   logic             dir_r, dir_n;
   logic [1:0]       kind_r, kind_n;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .q       (q),
      .dir     (dir_r),
      .kind    (kind_r),
      .ser_in  (ser_in),
      .q_next  (step_q),
      .out_bit (step_out)
   );

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         q       <= '0;
         ser_out <= 1'b0;
         done    <= 1'b0;
         dir_r   <= DIR_RIGHT;
         kind_r  <= KIND_LOGIC;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         q       <= q_n;
         ser_out <= ser_out_n;
         done    <= done_n;
         dir_r   <= dir_n;
         kind_r  <= kind_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      q_n       = q;
      ser_out_n = ser_out;
      done_n    = 1'b0;
      dir_n     = dir_r;
      kind_n    = kind_r;
      // load wins in both states; in SHIFT it aborts without a done pulse
      if (load) begin
         q_n     = data;
         cnt_n   = '0;
         state_n = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (amt != '0) begin
                     dir_n   = dir;
                     kind_n  = kind;
                     cnt_n   = amt;
                     state_n = ST_SHIFT;
                  end else begin
                     done_n = 1'b1;
                  end
               end
            end
            ST_SHIFT: begin
               if (ena) begin
                  q_n       = step_q;
                  ser_out_n = step_out;
                  cnt_n     = cnt - AMT_W'(1);
                  if (cnt == AMT_W'(1)) begin
                     state_n = ST_IDLE;
                     done_n  = 1'b1;
                  end
               end
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   assign busy = (state == ST_SHIFT);

endmodule

// File: tb/tb_shift_reg_seq.sv
// Scoreboard bench for shift_reg_seq: commands push the expected result, a
// monitor pops and compares on every done pulse.
module tb_shift_reg_seq;

   localparam int WIDTH = 8;
   localparam int AMT_W = $clog2(WIDTH) + 2;
   localparam logic [7:0] ONES = 8'hFF;

   logic             clk = 1'b0;
   logic             areset_n, load, start, dir, ser_in, ena;
   logic [1:0]       kind;
   logic [WIDTH-1:0] data;
   logic [AMT_W-1:0] amt;
   logic [WIDTH-1:0] q;
   logic             ser_out, busy, done;

   int checks = 0;
   int errors = 0;
   logic [8:0] sb[$];
   logic [8:0] mon_e;
   logic [7:0] mq;
   logic       mso;

   always #5 clk = ~clk;

   shift_reg_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
      .clk      (clk),
      .areset_n (areset_n),
      .load     (load),
      .data     (data),
      .start    (start),
      .dir      (dir),
      .kind     (kind),
      .amt      (amt),
      .ser_in   (ser_in),
      .ena      (ena),
      .q        (q),
      .ser_out  (ser_out),
      .busy     (busy),
      .done     (done)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Result of k shifts computed as whole-word arithmetic; {ser_out, q}.
   function automatic logic [8:0] model(input logic [7:0] q0, input logic so0, input logic d,
                                        input logic [1:0] kd, input int k, input logic c);
      logic [7:0] r;
      logic       so;
      int         m;
      if (k == 0) return {so0, q0};
      m = k % 8;
      if (d == 1'b0) begin
         case (kd)
            2'd0: begin
               r  = (k >= 8) ? 8'h00 : (q0 >> k);
               so = (k <= 8) ? q0[k-1] : 1'b0;
            end
            2'd1: begin
               r  = (k >= 8) ? {8{q0[7]}} : 8'($signed(q0) >>> k);
               so = (k <= 8) ? q0[k-1] : q0[7];
            end
            2'd2: begin
               r  = (q0 >> m) | (q0 << (8 - m));
               so = q0[(k-1) % 8];
            end
            default: begin
               r  = (k >= 8) ? {8{c}} : ((q0 >> k) | (c ? ~(ONES >> k) : 8'h00));
               so = (k <= 8) ? q0[k-1] : c;
            end
         endcase
      end else begin
         case (kd)
            2'd2: begin
               r  = (q0 << m) | (q0 >> (8 - m));
               so = q0[7 - ((k-1) % 8)];
            end
            2'd3: begin
               r  = (k >= 8) ? {8{c}} : ((q0 << k) | (c ? ~(ONES << k) : 8'h00));
               so = (k <= 8) ? q0[8-k] : c;
            end
            default: begin
               r  = (k >= 8) ? 8'h00 : (q0 << k);
               so = (k <= 8) ? q0[8-k] : 1'b0;
            end
         endcase
      end
      return {so, r};
   endfunction

   always @(negedge clk) begin
      if (areset_n === 1'b1 && done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("done_q", 32'(q), 32'(mon_e[7:0]));
            chk("done_ser_out", 32'(ser_out), 32'(mon_e[8]));
            chk("done_busy", 32'(busy), 32'd0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      areset_n = 1'b0;
      load = 1'b0; start = 1'b0; ena = 1'b0; ser_in = 1'b0;
      dir = 1'b0; kind = 2'd0; amt = '0; data = '0;
      repeat (2) tick();
      areset_n = 1'b1;
      tick();
      mq = 8'h00;
      mso = 1'b0;
   endtask

   task automatic do_load(input logic [7:0] v, input logic with_start);
      load = 1'b1; data = v; start = with_start; amt = AMT_W'(3);
      tick();
      load = 1'b0; start = 1'b0;
      mq = v;
      chk("load_q", 32'(q), 32'(v));
      chk("load_busy", 32'(busy), 32'd0);
      chk("load_done", 32'(done), 32'd0);
   endtask

   // stall_mode: 0 ena high, 1 two stall cycles mid-command, 2 random ena.
   task automatic run_cmd(input logic d, input logic [1:0] kd, input int k, input logic c,
                          input int stall_mode, input logic poke);
      logic [8:0] e;
      int steps = 0;
      int cyc = 0;
      e = model(mq, mso, d, kd, k, c);
      sb.push_back(e);
      mq = e[7:0];
      mso = e[8];
      dir = d; kind = kd; amt = AMT_W'(k); start = 1'b1;
      ser_in = (kd == 2'd3) ? c : 1'($urandom);
      ena = 1'($urandom);
      tick();
      start = 1'b0;
      dir = 1'($urandom); kind = 2'($urandom); amt = AMT_W'($urandom);
      if (k == 0) begin
         chk("zero_amt_done", 32'(done), 32'd1);
         chk("zero_amt_busy", 32'(busy), 32'd0);
         return;
      end
      while (steps < k) begin
         chk("busy_during_cmd", 32'(busy), 32'd1);
         case (stall_mode)
            1:       ena = (cyc == 1 || cyc == 2) ? 1'b0 : 1'b1;
            2:       ena = ($urandom_range(0, 3) != 0);
            default: ena = 1'b1;
         endcase
         if (poke && cyc == 1) begin
            start = 1'b1; dir = ~d; kind = kd + 2'd1; amt = AMT_W'(1);
         end else begin
            start = 1'b0;
         end
         ser_in = (kd == 2'd3) ? c : 1'($urandom);
         if (ena) steps++;
         cyc++;
         tick();
      end
      start = 1'b0;
      ena = 1'b0;
      chk("cmd_done", 32'(done), 32'd1);
      chk("cmd_busy_end", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [8:0] ab;
      do_reset();
      chk("reset_q", 32'(q), 32'd0);
      chk("reset_ser_out", 32'(ser_out), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);

      // reset in the middle of a command
      do_load(8'hB4, 1'b0);
      dir = 1'b0; kind = 2'd0; amt = AMT_W'(5); start = 1'b1; ena = 1'b1;
      tick();
      start = 1'b0;
      repeat (2) tick();
      areset_n = 1'b0;
      #1;
      chk("rst_mid_q", 32'(q), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_done", 32'(done), 32'd0);
      chk("rst_mid_ser_out", 32'(ser_out), 32'd0);
      tick();
      areset_n = 1'b1;
      ena = 1'b0;
      mq = 8'h00;
      mso = 1'b0;
      repeat (3) begin
         tick();
         chk("rst_mid_no_done", 32'(done), 32'd0);
      end

      do_load(8'hB4, 1'b0);
      run_cmd(1'b0, 2'd0, 3, 1'b0, 0, 1'b0);
      chk("right_logic_q", 32'(q), 32'h16);
      chk("right_logic_so", 32'(ser_out), 32'd1);
      do_load(8'h96, 1'b0);
      run_cmd(1'b0, 2'd1, 2, 1'b0, 0, 1'b0);
      chk("right_arith_q", 32'(q), 32'hE5);
      do_load(8'h00, 1'b0);
      run_cmd(1'b0, 2'd3, 8, 1'b1, 0, 1'b0);
      chk("right_serial_q", 32'(q), 32'hFF);
      do_load(8'h81, 1'b0);
      run_cmd(1'b1, 2'd2, 1, 1'b0, 0, 1'b0);
      chk("rotl1_q", 32'(q), 32'h03);
      do_load(8'h81, 1'b0);
      run_cmd(1'b1, 2'd2, 9, 1'b0, 0, 1'b0);
      chk("rotl9_q", 32'(q), 32'h03);
      do_load(8'h81, 1'b0);
      run_cmd(1'b1, 2'd2, 0, 1'b0, 0, 1'b0);
      chk("rotl0_q", 32'(q), 32'h81);

      do_load(8'hB4, 1'b0);
      run_cmd(1'b0, 2'd0, 4, 1'b0, 1, 1'b0);
      chk("stall_q", 32'(q), 32'h0B);

      // abort by load during SHIFT
      do_load(8'h3C, 1'b0);
      ab = model(mq, mso, 1'b0, 2'd0, 2, 1'b0);
      dir = 1'b0; kind = 2'd0; amt = AMT_W'(6); start = 1'b1; ena = 1'b1;
      tick();
      start = 1'b0;
      repeat (2) tick();
      load = 1'b1; data = 8'h5A;
      tick();
      load = 1'b0; ena = 1'b0;
      mq = 8'h5A;
      mso = ab[8];
      chk("abort_q", 32'(q), 32'h5A);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_ser_out", 32'(ser_out), 32'(ab[8]));
      tick();
      chk("abort_no_done", 32'(done), 32'd0);

      do_load(8'hA7, 1'b0);
      run_cmd(1'b1, 2'd0, 3, 1'b0, 0, 1'b1);
      chk("poke_q", 32'(q), 32'h38);

      do_load(8'h42, 1'b1);
      tick();
      chk("load_start_busy", 32'(busy), 32'd0);
      chk("load_start_done", 32'(done), 32'd0);

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 2) == 0) do_load(8'($urandom), 1'b0);
         run_cmd(1'($urandom), 2'($urandom), int'($urandom_range(0, 20)), 1'($urandom),
                 2, ($urandom_range(0, 4) == 0));
      end

      repeat (3) tick();
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
